// File: rtl/bytewrite_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bytewrite_ram_port_ctrl
// Brief    : Port-A controller for a byte-write RAM (2-cycle read latency).
//            It zero-fills the RAM after reset, then serves posted writes and
//            credit-limited reads, and returns read data in order.
// Revision : 1.0 - initial release
// ============================================================================
module bytewrite_ram_port_ctrl #(
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 9,
  parameter int ADDR_W    = 10,
  parameter int RAM_DEPTH = 1024,
  parameter int RSP_DEPTH = 4
) (
  input  logic                          clka,
  input  logic                          rstb,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [NB_COL-1:0]             req_be,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NB_COL*COL_WIDTH-1:0]   rsp_rdata,
  output logic                          init_done,
  output logic [ADDR_W-1:0]             ram_addra,
  output logic [NB_COL*COL_WIDTH-1:0]   ram_dina,
  output logic [NB_COL-1:0]             ram_wea,
  output logic                          ram_ena,
  output logic                          ram_regcea,
  output logic                          ram_rsta,
  input  logic [NB_COL*COL_WIDTH-1:0]   ram_douta
);

  localparam int c_W     = NB_COL * COL_WIDTH;
  localparam int c_PTR_W = $clog2(RSP_DEPTH);
  localparam int c_CRD_W = c_PTR_W + 1;
  localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [c_CRD_W-1:0] c_MAX_CRD   = c_CRD_W'(RSP_DEPTH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_init_addr;
  logic                 r_init_done;
  logic [1:0]           r_inflight;
  logic [c_CRD_W-1:0]   r_credits;
  logic [c_PTR_W:0]     r_wptr;
  logic [c_PTR_W:0]     r_rptr;
  logic [c_W-1:0]       r_fifo [RSP_DEPTH];

  logic w_init_wr;
  logic w_run;
  logic w_accept;
  logic w_rd_accept;
  logic w_wr_en;
  logic w_push;
  logic w_pop;
  logic w_empty;

  // Every externally visible control is masked by reset so the RAM sees no
  // stray access in the cycle before the synchronous reset takes effect.
  assign w_init_wr   = (r_state == ST_INIT) & ~rstb;
  assign w_run       = (r_state == ST_RUN) & ~rstb;
  assign req_ready   = w_run & (r_credits < c_MAX_CRD);
  assign w_accept    = req_valid & req_ready;
  assign w_rd_accept = w_accept & ~req_we;
  assign w_wr_en     = w_accept & req_we & (|req_be);

  assign w_empty   = (r_wptr == r_rptr);
  assign w_push    = r_inflight[1] & ~rstb;
  assign rsp_valid = ~w_empty & ~rstb;
  assign w_pop     = rsp_valid & rsp_ready;
  assign rsp_rdata = r_fifo[r_rptr[c_PTR_W-1:0]];

  assign init_done  = r_init_done & ~rstb;
  assign ram_regcea = r_inflight[0] & ~rstb;
  assign ram_rsta   = rstb;

  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = '0;
    ram_addra = '0;
    ram_dina  = '0;
    if (w_init_wr) begin
      ram_ena   = 1'b1;
      ram_wea   = '1;
      ram_addra = r_init_addr;
    end else if (w_run) begin
      ram_ena   = w_rd_accept | w_wr_en;
      ram_wea   = req_we ? req_be : '0;
      ram_addra = req_addr;
      ram_dina  = req_wdata;
    end
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
      r_inflight  <= '0;
      r_credits   <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        if (r_init_addr == c_LAST_ADDR) begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end else begin
          r_init_addr <= r_init_addr + ADDR_W'(1);
        end
      end
      r_inflight <= {r_inflight[0], w_rd_accept};
      // Credits cover reads in the RAM pipeline plus queued responses.
      if (w_rd_accept && !w_pop) begin
        r_credits <= r_credits + c_CRD_W'(1);
      end else if (!w_rd_accept && w_pop) begin
        r_credits <= r_credits - c_CRD_W'(1);
      end
      if (w_push) begin
        r_wptr <= r_wptr + (c_PTR_W + 1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (c_PTR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clka) begin
    if (w_push) begin
      r_fifo[r_wptr[c_PTR_W-1:0]] <= ram_douta;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bytewrite_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bytewrite_ram_port_ctrl
// Brief    : Scoreboard bench with a behavioural byte-write RAM and a
//            word-level memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bytewrite_ram_port_ctrl;

  localparam int NB_COL    = 4;
  localparam int COL_WIDTH = 9;
  localparam int ADDR_W    = 10;
  localparam int RAM_DEPTH = 1024;
  localparam int RSP_DEPTH = 4;
  localparam int W         = NB_COL * COL_WIDTH;
  localparam logic [W-1:0] c_GARBAGE = 36'hDEADBEEF5;

  logic              clka = 1'b0;
  logic              rstb;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [NB_COL-1:0] req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [W-1:0]      req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_rdata;
  logic              init_done;
  logic [ADDR_W-1:0] ram_addra;
  logic [W-1:0]      ram_dina;
  logic [NB_COL-1:0] ram_wea;
  logic              ram_ena;
  logic              ram_regcea;
  logic              ram_rsta;
  logic [W-1:0]      ram_douta;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit rnd_rdy = 1'b0;

  always #5 clka = ~clka;

  bytewrite_ram_port_ctrl #(
    .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_W(ADDR_W),
    .RAM_DEPTH(RAM_DEPTH), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clka(clka), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_ena(ram_ena), .ram_regcea(ram_regcea), .ram_rsta(ram_rsta),
    .ram_douta(ram_douta)
  );

  function automatic logic [W-1:0] merge(input logic [W-1:0] old,
                                         input logic [W-1:0] din,
                                         input logic [NB_COL-1:0] be);
    logic [W-1:0] r;
    r = old;
    for (int b = 0; b < NB_COL; b++)
      if (be[b]) r[b*COL_WIDTH +: COL_WIDTH] = din[b*COL_WIDTH +: COL_WIDTH];
    return r;
  endfunction

  // Downstream RAM: write-first, output register behind regce; unwritten words read as garbage.
  logic [W-1:0] ram [RAM_DEPTH];
  bit           ram_wr [RAM_DEPTH];
  logic [W-1:0] ram_q1;

  always @(posedge clka) begin
    if (ram_ena) begin
      ram[ram_addra]    <= merge(ram_wr[ram_addra] ? ram[ram_addra] : c_GARBAGE, ram_dina, ram_wea);
      ram_q1            <= merge(ram_wr[ram_addra] ? ram[ram_addra] : c_GARBAGE, ram_dina, ram_wea);
      ram_wr[ram_addra] <= 1'b1;
    end
    if (ram_rsta) ram_douta <= '0;
    else if (ram_regcea) ram_douta <= ram_q1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard
  logic [W-1:0] ref_mem [RAM_DEPTH];
  logic [W-1:0] exp_q [$];
  int           acc_q [$];
  int           n_since = 0;
  bit           prev_rd = 1'b0;

  initial begin
    bit model_ready, acc, rd;
    forever begin
      @(negedge clka);
      cyc++;
      if (rstb) begin
        chk("reset_outputs",
            64'({req_ready, rsp_valid, init_done, ram_ena, ram_wea, ram_regcea, ram_rsta}),
            64'(10'b0000000001));
        exp_q.delete();
        acc_q.delete();
        n_since = 0;
        prev_rd = 1'b0;
        for (int i = 0; i < RAM_DEPTH; i++) ref_mem[i] = '0;
      end else begin
        if (n_since < RAM_DEPTH) begin
          chk("init_write",
              64'({init_done, req_ready, ram_ena, ram_wea, ram_addra, ram_dina, ram_regcea, rsp_valid}),
              64'({1'b0, 1'b0, 1'b1, 4'hF, 10'(n_since), 36'h0, 1'b0, 1'b0}));
        end else begin
          model_ready = (exp_q.size() < RSP_DEPTH);
          chk("init_done", 64'(init_done), 64'(1));
          chk("req_ready", 64'(req_ready), 64'(model_ready));
          chk("regcea", 64'(ram_regcea), 64'(prev_rd));
          acc = req_valid && model_ready;
          rd  = acc && !req_we;
          if (exp_q.size() > 0 && cyc >= acc_q[0] + 3)
            chk("rsp_valid_due", 64'(rsp_valid), 64'(1));
          if (rsp_valid) begin
            if (exp_q.size() == 0) begin
              chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
              chk("rsp_early", 64'(cyc >= acc_q[0] + 3), 64'(1));
              chk("rsp_data", 64'(rsp_rdata), 64'(exp_q[0]));
              if (rsp_ready) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
              end
            end
          end
          if (rd) begin
            chk("ram_read", 64'({ram_ena, ram_wea, ram_addra}), 64'({1'b1, 4'h0, req_addr}));
            exp_q.push_back(ref_mem[req_addr]);
            acc_q.push_back(cyc);
          end else if (acc && req_be != '0) begin
            chk("ram_write", 64'({ram_ena, ram_wea, ram_addra, ram_dina}),
                64'({1'b1, req_be, req_addr, req_wdata}));
            ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_be);
          end else if (acc) begin
            chk("empty_mask", 64'(ram_ena), 64'(0));
          end else begin
            chk("ram_idle", 64'(ram_ena), 64'(0));
          end
          prev_rd = rd;
        end
        n_since++;
      end
    end
  end

  initial forever begin
    @(posedge clka); #1;
    if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic we, input logic [NB_COL-1:0] be,
                      input logic [ADDR_W-1:0] addr, input logic [W-1:0] d);
    int t;
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = d;
    t = 0;
    forever begin
      @(negedge clka);
      if (req_ready) break;
      t++;
      if (t > 200) begin
        chk("send_timeout", 64'(req_ready), 64'(1));
        break;
      end
    end
    @(posedge clka); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_init();
    int t;
    t = 0;
    while (!init_done && t < 1200) begin
      @(negedge clka);
      t++;
    end
    chk("init_wait", 64'(init_done), 64'(1));
    @(posedge clka); #1;
  endtask

  task automatic read_expect(input string name, input logic [ADDR_W-1:0] addr,
                             input logic [W-1:0] expv);
    int t;
    send(1'b0, '0, addr, '0);
    t = 0;
    @(negedge clka);
    while (!rsp_valid && t < 10) begin
      @(negedge clka);
      t++;
    end
    chk(name, 64'({rsp_valid, rsp_rdata}), 64'({1'b1, expv}));
    @(posedge clka); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clka);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clka); #1;
  endtask

  initial begin
    int n_acc;
    rstb = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_be = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clka);
    #1 rstb = 1'b0;
    wait_init();

    read_expect("zero_fill_read", 10'd5, 36'h0);

    send(1'b1, 4'hF, 10'd3, 36'h123456789);
    send(1'b1, 4'b0001, 10'd3, 36'h1FF);
    read_expect("byte_write_read", 10'd3, 36'h1234567FF);

    send(1'b1, 4'hF, 10'd7, 36'hA);
    send(1'b1, 4'h0, 10'd7, 36'hFFFFFFFFF);
    read_expect("empty_mask_read", 10'd7, 36'hA);

    // Backpressure: fill all credits with responses held off
    for (int i = 0; i < 6; i++) send(1'b1, 4'hF, ADDR_W'(100 + i), W'({$urandom(), $urandom()}));
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_be = '0; req_addr = 10'd100;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clka);
      if (req_ready) n_acc++;
      @(posedge clka); #1;
      if (n_acc < 6) req_addr = ADDR_W'(100 + n_acc);
    end
    @(negedge clka);
    chk("bp_accepted", 64'(n_acc), 64'(4));
    chk("bp_ready_low", 64'(req_ready), 64'(0));
    @(posedge clka); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Randomised traffic with random response backpressure
    rnd_rdy = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clka); #1;
      end
      send(1'($urandom_range(0, 1)), NB_COL'($urandom_range(0, 15)),
           ADDR_W'($urandom_range(0, 15)), W'({$urandom(), $urandom()}));
    end
    rnd_rdy = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Reset with two reads queued and two still in the RAM pipeline
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(1'b0, '0, ADDR_W'(i), '0);
    rstb = 1'b1;
    repeat (3) @(posedge clka);
    #1 rstb = 1'b0;
    rsp_ready = 1'b1;
    wait_init();
    read_expect("post_reset_read", 10'd3, 36'h0);
    drain();

    repeat (2) @(posedge clka);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bytewrite_ram_port_ctrl.md
BYTEWRITE_RAM_PORT_CTRL -- requirements
Module: bytewrite_ram_port_ctrl

Interface
REQ-001 The block SHALL have parameter NB_COL, default 4, number of byte lanes.
REQ-002 The block SHALL have parameter COL_WIDTH, default 9, bits per lane.
REQ-003 The block SHALL have parameters ADDR_W (default 10, address bits) and RAM_DEPTH (default 1024, entries).
REQ-004 The block SHALL have parameter RSP_DEPTH, default 4, response FIFO entries (power of two, 2..16).
REQ-005 The ports SHALL be as follows, with W = NB_COL*COL_WIDTH:
- clka  in  1  clock; every register in the block is clocked on its rising edge.
- rstb  in  1  reset, synchronous, active-high.
- req_valid in 1; req_ready out 1; req_we in 1 (1 = write, 0 = read).
- req_be in NB_COL (write lane mask); req_addr in ADDR_W; req_wdata in W.
- rsp_valid out 1; rsp_ready in 1; rsp_rdata out W (read data, in request order).
- init_done out 1 (RAM zero-fill complete).
- ram_addra out ADDR_W; ram_dina out W; ram_wea out NB_COL; ram_ena out 1; ram_regcea out 1; ram_rsta out 1; ram_douta in W.
- These drive port A of the downstream byte-write RAM, which has write-first behaviour and 2-cycle registered-output read latency.

Function
REQ-006 The FSM SHALL have two states: INIT and RUN; reset enters INIT.
REQ-007 In INIT, the block SHALL issue one write per cycle:
- addresses 0..RAM_DEPTH-1 in ascending order;
- ram_ena=1, ram_wea all ones, ram_dina=0;
- req_ready=0.
REQ-008 After the write to RAM_DEPTH-1, the FSM SHALL enter RUN, and init_done SHALL be 1 from the next cycle until reset.
REQ-009 In RUN, req_ready SHALL be 1 iff credits < RSP_DEPTH, where credits = reads in flight + FIFO occupancy.
REQ-010 A request SHALL be accepted on an edge where req_valid and req_ready are both 1; req_addr, req_we, req_be and req_wdata SHALL be sampled on that edge.
REQ-011 In RUN, RAM drive SHALL be combinational from the request:
- ram_ena = req_valid & req_ready & (!req_we | (req_be != 0));
- ram_wea = req_we ? req_be : 0;
- ram_addra = req_addr;
- ram_dina = req_wdata.
REQ-012 A write with req_be == 0 SHALL be accepted as a no-op: no RAM access, no response.
REQ-013 Writes SHALL be posted (no response) and SHALL NOT change credits.
REQ-014 A read accepted at edge n SHALL behave as follows:
- ram_regcea=1 during cycle n..n+1;
- ram_douta SHALL be pushed into the FIFO at edge n+2;
- rsp_valid SHALL be 1 from edge n+2 at the earliest.
REQ-015 A 2-stage in-flight shift register SHALL track outstanding reads; ram_regcea SHALL equal stage 1.
REQ-016 credits SHALL update as follows:
- +1 on read accept;
- -1 on rsp_valid & rsp_ready;
- unchanged when both occur on the same edge.
REQ-017 The FIFO SHALL never overflow, since credits bound occupancy; push and pop on the same edge SHALL be legal, including when the FIFO is full or empty.
REQ-018 Responses SHALL be returned strictly in read-acceptance order; read pointers SHALL wrap modulo RSP_DEPTH.
REQ-019 rsp_rdata SHALL be driven from the FIFO head and SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-020 Read-after-write to the same address SHALL return the new data, guaranteed by single-port ordering.
REQ-021 A write accepted in the same cycle as an earlier read's pipeline SHALL NOT disturb that read's data.

Reset
REQ-022 While rstb=1, the outputs SHALL be:
- req_ready=0, rsp_valid=0, init_done=0;
- ram_ena=0, ram_wea=0, ram_regcea=0;
- ram_rsta=1.
REQ-023 Reset SHALL clear credits, the in-flight pipeline, FIFO pointers and the FSM (to INIT, address counter 0).
REQ-024 A reset asserted mid-operation SHALL discard pending responses; INIT SHALL restart after rstb deasserts.
REQ-025 ram_rsta SHALL equal rstb.

Verification
REQ-026 Zero-fill: release reset with RAM_DEPTH=1024 -> 1024 consecutive writes to 0..1023 with wea=4'hF; init_done rises 1 cycle after address 1023; a read of address 5 returns 0.
REQ-027 Byte write: write addr 3 data 36'h123456789 be=4'hF, then addr 3 data 36'h1FF be=4'b0001, then read addr 3 -> rsp_rdata=36'h1234567FF.
REQ-028 Latency: read accepted at edge n with rsp_ready=1 -> rsp_valid=1 after edge n+2, for exactly one cycle.
REQ-029 Backpressure: rsp_ready=0 with 6 back-to-back reads offered -> exactly 4 accepted, then req_ready=0; raise rsp_ready -> 4 in-order responses, and req_ready returns the cycle after the first pop.
REQ-030 Empty mask: write with be=0 to addr 7 (holding 36'hA) -> ram_ena stays 0; a subsequent read returns 36'hA.
REQ-031 Mid-reset: reset asserted with 2 reads in flight and 2 responses queued -> rsp_valid=0 the next cycle; no stale responses after re-init; init_done re-rises after 1024 cycles.
